muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit.
- Consumes the 4-bit ALU operation codes 4'b1000..4'b1111 produced by the ALU control decoder.
- Sits in EX beside the single-cycle ALU. The pipeline stalls on busy and captures result on done.
- Uses a shift-add multiplier and a restoring divider, one bit per cycle, with fixed latency.

Parameters:
XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
op  input  4  operation: 1000 MUL, 1001 MULH, 1010 MULHU, 1011 MULHSU, 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
a  input  XLEN  rs1 operand (multiplicand / dividend)
b  input  XLEN  rs2 operand (multiplier / divisor)
flush  input  1  synchronous abort (branch mispredict / trap)
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse; result valid from this cycle
result  output  XLEN  final value; held until the next done

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low on rst_n.
  - On reset: state=IDLE, busy=0, done=0, result=0, all internal registers=0.
  - Reset mid-operation aborts immediately; no done is produced.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- IDLE:
  - Accept occurs when start=1 and op[3]=1.
  - On accept: latch op and operand sign flags, convert operands to magnitudes per signedness, clear the 2*XLEN accumulator, set count=0, go to CALC, set busy=1 from the next cycle.
  - start with op[3]=0 is ignored: no busy, no done.
  - start while not IDLE is ignored; there is no queueing.
- CALC, one step per cycle for XLEN cycles:
  - MUL*: if the multiplier LSB is set, add the multiplicand to the high half; then shift right.
  - DIV*/REM*: shift remainder:quotient left by 1; trial-subtract the divisor; keep the difference and set the quotient bit if it is non-negative.
  - count increments each step; on count==XLEN-1, go to FIX.
- Signedness:
  - MUL: low word of the product.
  - MULH: signed x signed, high word.
  - MULHU: unsigned x unsigned, high word.
  - MULHSU: signed a x unsigned b, high word.
  - DIV/REM: signed. DIVU/REMU: unsigned.
- FIX (1 cycle):
  - Apply the sign correction: negate the 2*XLEN product if the sign flags differ; negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the low or high word, or the quotient or remainder.
  - Register the value into result. Go to DONE.
- Special cases, applied in FIX and overriding the datapath:
  - Divisor==0: DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
  - A start in this cycle is ignored.
  - The earliest next accept is the cycle after done.
- Latency:
  - Accept at edge T0; busy high at T0+1 .. T0+XLEN+1.
  - done high in cycle T0+XLEN+2, which is 34 for XLEN=32.
  - Latency is fixed for all ops, including the special cases.
- flush:
  - In CALC or FIX: return to IDLE at the next edge; busy drops; no done; result keeps its previous value.
  - In DONE: the done pulse still completes.
  - In IDLE: has priority over start, so nothing is accepted.
- result changes only in FIX; it is stable at all other times.

Test Plan:
- Reset during CALC (rst_n low at cycle 10) -> busy, done and result go to 0 immediately, with no clock edge needed.
- MUL a=7, b=0xFFFFFFFD -> done exactly 34 cycles after accept, result=0xFFFFFFEB, busy high for 33 cycles.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide and remainder:
  - DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD.
  - REM same operands -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14.
  - REMU 100/7 -> 2.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF.
  - REMU 5/0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
  - All of these still complete at cycle 34.
- Flush and ignored requests:
  - flush at cycle 10 of a DIV -> busy low at the next edge, no done, result unchanged from the prior op; a new MUL is then accepted and completes normally.
  - start asserted while busy -> ignored.
  - start with op=4'b0000 -> no busy.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider, one bit per cycle, fixed XLEN+2 cycle latency from accept to done.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              sa_q, sa_d, sb_q, sb_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   a_q, a_d, dvs_q, dvs_d, result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic              sgn_a, sgn_b, a_neg, b_neg, ge;
  logic [XLEN-1:0]   a_mag, b_mag, quo, rem, fix_val;
  logic [XLEN:0]     sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod, step;

  always_comb begin
    // Operand signedness: divide ops are signed when op[0]=0; MULH/MULHSU sign a, only MULH signs b
    sgn_a = op[2] ? ~op[0] : op[0];
    sgn_b = op[2] ? ~op[0] : (op[1:0] == 2'b01);
    a_neg = sgn_a & a[XLEN-1];
    b_neg = sgn_b & b[XLEN-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;

    // acc holds {high, multiplier} for multiply and {remainder, quotient} for divide
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    ge     = rem_sh >= {1'b0, dvs_q};
    diff   = rem_sh - {1'b0, dvs_q};
    if (!op_q[2])
      step = {sum, acc_q[XLEN-1:1]};
    else if (ge)
      step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    else
      step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    if (!op_q[2])
      fix_val = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (dvs_q == '0)
      fix_val = op_q[1] ? a_q : '1;
    else if (ovf_q)
      fix_val = op_q[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    else
      fix_val = op_q[1] ? rem : quo;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (start && op[3] && !flush) begin
        op_d    = op[2:0];
        sa_d    = a_neg;
        sb_d    = b_neg;
        a_d     = a;
        ovf_d   = op[2] && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (&b);
        acc_d   = op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
        dvs_d   = op[2] ? b_mag : a_mag;
        cnt_d   = '0;
        state_d = CALC;
      end
      CALC: if (flush) state_d = IDLE;
      else begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      end
      FIX: if (flush) state_d = IDLE;
      else begin
        result_d = fix_val;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ovf_q    <= 1'b0;
      a_q      <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ovf_q    <= ovf_d;
      a_q      <= a_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == CALC) || (state_q == FIX);
  assign done   = (state_q == DONE);
  assign result = result_q;
endmodule
